// File: rtl/ysyx_22041461_ifu_pkg.sv
// rtl/ysyx_22041461_ifu_pkg.sv - shared state encoding, constants and helpers for the instruction fetch unit
package ysyx_22041461_ifu_pkg;

  // One-hot so that each handshake output is a single state flop.
  typedef enum logic [4:0] {
    IDLE = 5'b00001,
    REQ  = 5'b00010,
    WAIT = 5'b00100,
    HOLD = 5'b01000,
    DROP = 5'b10000
  } ifu_state_e;

  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

  // Pick the 32-bit instruction out of an 8-byte beat using pc bit 2.
  function automatic logic [31:0] sel_word(input logic [63:0] rdata, input logic a2);
    return a2 ? rdata[63:32] : rdata[31:0];
  endfunction

  // Watchdog counter width: clog2(cycles)+1, clamped to 8..32 bits.
  function automatic int tmo_width(input int cycles);
    int w;
    w = $clog2(cycles) + 1;
    if (w < 8) w = 8;
    if (w > 32) w = 32;
    return w;
  endfunction

endpackage

// File: rtl/ysyx_22041461_ifu.sv
// rtl/ysyx_22041461_ifu.sv - instruction fetch unit, one outstanding read; optional watchdog under YSYX_22041461_IFU_TIMEOUT_EN
module ysyx_22041461_ifu
  import ysyx_22041461_ifu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] NOP_INST       = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] pc_i,
  input  logic        pc_valid_i,
  output logic        pc_ready_o,
  input  logic        flush_i,
  output logic        mem_arvalid_o,
  input  logic        mem_arready_i,
  output logic [63:0] mem_araddr_o,
  input  logic        mem_rvalid_i,
  output logic        mem_rready_o,
  input  logic [63:0] mem_rdata_i,
  input  logic [1:0]  mem_rresp_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [63:0] inst_pc_o,
  output logic        inst_fault_o
);

  ifu_state_e  r_state;
  logic [63:0] r_pc;
  logic [31:0] r_inst;
  logic        r_fault;
  logic        r_drop_pending;

  logic        w_tmo_hit;
  logic        w_late;
  logic        w_rfault;

  assign w_rfault = (mem_rresp_i != RESP_OKAY);

`ifdef YSYX_22041461_IFU_TIMEOUT_EN
  localparam int TMO_W = tmo_width(int'(TIMEOUT_CYCLES));

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_late_pending;

  assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign w_late    = r_late_pending;

  // watchdog: count WAIT cycles since the AR handshake and remember a response still owed after a timeout
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tmo_cnt      <= '0;
      r_late_pending <= 1'b0;
    end else begin
      if (r_state == REQ && mem_arready_i) begin
        r_tmo_cnt <= '0;
      end else if (r_state == WAIT && !mem_rvalid_i) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
      if (r_state == WAIT && !mem_rvalid_i && !flush_i && w_tmo_hit) begin
        r_late_pending <= 1'b1;
      end else if (r_state == DROP && mem_rvalid_i) begin
        r_late_pending <= 1'b0;
      end
    end
  end
`else
  logic w_unused_tmo;

  assign w_tmo_hit    = 1'b0;
  assign w_late       = 1'b0;
  assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

  // fetch sequencing: accept pc, issue the read, hold the instruction for decode, or drain a cancelled read
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_pc           <= '0;
      r_inst         <= '0;
      r_fault        <= 1'b0;
      r_drop_pending <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (pc_valid_i && !flush_i) begin
            r_pc <= pc_i;
            if (pc_i[1:0] != 2'b00) begin
              // misaligned: report without touching the bus
              r_state <= HOLD;
              r_fault <= 1'b1;
              r_inst  <= NOP_INST;
            end else begin
              r_state <= REQ;
              r_fault <= 1'b0;
            end
          end
        end
        REQ: begin
          // arvalid stays up once raised; a flush only marks the answer as unwanted
          if (mem_arready_i) begin
            r_state        <= (r_drop_pending || flush_i) ? DROP : WAIT;
            r_drop_pending <= 1'b0;
          end else if (flush_i) begin
            r_drop_pending <= 1'b1;
          end
        end
        WAIT: begin
          if (mem_rvalid_i) begin
            if (flush_i) begin
              r_state <= IDLE;
            end else begin
              r_state <= HOLD;
              r_fault <= w_rfault;
              r_inst  <= w_rfault ? NOP_INST : sel_word(mem_rdata_i, r_pc[2]);
            end
          end else if (flush_i) begin
            r_state <= DROP;
          end else if (w_tmo_hit) begin
            r_state <= HOLD;
            r_fault <= 1'b1;
            r_inst  <= NOP_INST;
          end
        end
        HOLD: begin
          // flush and ready both release the slot; a late response must be drained first
          if (flush_i || inst_ready_i) begin
            r_state <= w_late ? DROP : IDLE;
          end
        end
        DROP: begin
          if (mem_rvalid_i) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign pc_ready_o    = (r_state == IDLE);
  assign mem_arvalid_o = (r_state == REQ);
  assign mem_araddr_o  = {r_pc[63:3], 3'b000};
  assign mem_rready_o  = (r_state == WAIT) || (r_state == DROP);
  assign inst_valid_o  = (r_state == HOLD);
  assign inst_o        = r_inst;
  assign inst_pc_o     = r_pc;
  assign inst_fault_o  = r_fault;

endmodule

// File: tb/tb_ysyx_22041461_ifu.sv
// tb/tb_ysyx_22041461_ifu.sv - scoreboard bench for the instruction fetch unit
module tb_ysyx_22041461_ifu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] pc_i = '0;
  logic        pc_valid_i = 1'b0;
  logic        pc_ready_o;
  logic        flush_i = 1'b0;
  logic        mem_arvalid_o;
  logic        mem_arready_i = 1'b0;
  logic [63:0] mem_araddr_o;
  logic        mem_rvalid_i = 1'b0;
  logic        mem_rready_o;
  logic [63:0] mem_rdata_i = '0;
  logic [1:0]  mem_rresp_i = '0;
  logic        inst_valid_o;
  logic        inst_ready_i = 1'b0;
  logic [31:0] inst_o;
  logic [63:0] inst_pc_o;
  logic        inst_fault_o;

  always #5 clk = ~clk;

  ysyx_22041461_ifu #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .pc_i(pc_i), .pc_valid_i(pc_valid_i), .pc_ready_o(pc_ready_o), .flush_i(flush_i),
    .mem_arvalid_o(mem_arvalid_o), .mem_arready_i(mem_arready_i), .mem_araddr_o(mem_araddr_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rready_o(mem_rready_o), .mem_rdata_i(mem_rdata_i),
    .mem_rresp_i(mem_rresp_i),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i), .inst_o(inst_o),
    .inst_pc_o(inst_pc_o), .inst_fault_o(inst_fault_o)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_ar = 0, n_r = 0, n_arv = 0, n_xfer = 0, n_valid = 0;
  int m_ar_delay = 0, m_r_delay = 0;
  logic [63:0] m_rdata = '0;
  logic [1:0]  m_rresp = '0;
  logic [63:0] exp_araddr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] inst, input logic [63:0] pc, input logic fault);
    exp_t e;
    e.inst  = inst;
    e.pc    = pc;
    e.fault = fault;
    exp_q.push_back(e);
  endtask

  // memory responder: programmable AR and R delays, updated just after each clock edge
  initial begin : mem_model
    int ar_cnt, r_cnt;
    bit r_pend, ar_hs, r_hs;
    ar_cnt = 0; r_cnt = 0; r_pend = 0; ar_hs = 0; r_hs = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        ar_cnt = 0; r_cnt = 0; r_pend = 0; ar_hs = 0; r_hs = 0;
        mem_arready_i = 1'b0;
        mem_rvalid_i  = 1'b0;
      end else begin
        if (r_hs) begin
          r_pend = 0;
          mem_rvalid_i = 1'b0;
          n_r++;
        end
        if (ar_hs) begin
          r_pend = 1;
          r_cnt = 0;
          n_ar++;
        end
        if (mem_arvalid_o) begin
          n_arv++;
          chk("araddr_stable", mem_araddr_o, exp_araddr);
          if (ar_cnt >= m_ar_delay) mem_arready_i = 1'b1;
          else begin
            mem_arready_i = 1'b0;
            ar_cnt++;
          end
        end else begin
          mem_arready_i = 1'b0;
          ar_cnt = 0;
        end
        if (r_pend && !mem_rvalid_i) begin
          if (r_cnt >= m_r_delay) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = m_rdata;
            mem_rresp_i  = m_rresp;
          end else begin
            r_cnt++;
          end
        end
        ar_hs = mem_arvalid_o && mem_arready_i;
        r_hs  = mem_rvalid_i && mem_rready_o;
      end
    end
  end

  // monitor: pops the scoreboard on each IDU transfer and checks hold stability
  initial begin : monitor
    exp_t e;
    logic held;
    logic [31:0] h_inst;
    logic [63:0] h_pc;
    logic h_fault;
    held = 1'b0; h_inst = '0; h_pc = '0; h_fault = 1'b0;
    forever begin
      @(negedge clk); #2;
      if (rst && inst_valid_o) begin
        n_valid++;
        if (held) begin
          chk("hold_inst", 64'(inst_o), 64'(h_inst));
          chk("hold_pc", inst_pc_o, h_pc);
          chk("hold_fault", 64'(inst_fault_o), 64'(h_fault));
        end
        if (inst_ready_i && !flush_i) begin
          n_xfer++;
          chk("xfer_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("inst", 64'(inst_o), 64'(e.inst));
            chk("inst_pc", inst_pc_o, e.pc);
            chk("inst_fault", 64'(inst_fault_o), 64'(e.fault));
          end
        end
        held    = !(inst_ready_i || flush_i);
        h_inst  = inst_o;
        h_pc    = inst_pc_o;
        h_fault = inst_fault_o;
      end else begin
        held = 1'b0;
      end
    end
  end

  task automatic issue(input logic [63:0] pc);
    chk("issue_pc_ready", 64'(pc_ready_o), 64'd1);
    exp_araddr = {pc[63:3], 3'b000};
    pc_i = pc;
    pc_valid_i = 1'b1;
    @(negedge clk);
    pc_valid_i = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!inst_valid_o && cyc < 100) begin
      chk("busy_pc_ready", 64'(pc_ready_o), 64'd0);
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (!pc_ready_o && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("idle_reached", 64'(cyc < 200), 64'd1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pc_ready"}, 64'(pc_ready_o), 64'd1);
    chk({tag, "_arvalid"}, 64'(mem_arvalid_o), 64'd0);
    chk({tag, "_araddr"}, mem_araddr_o, 64'd0);
    chk({tag, "_rready"}, 64'(mem_rready_o), 64'd0);
    chk({tag, "_inst_valid"}, 64'(inst_valid_o), 64'd0);
    chk({tag, "_inst"}, 64'(inst_o), 64'd0);
    chk({tag, "_inst_pc"}, inst_pc_o, 64'd0);
    chk({tag, "_fault"}, 64'(inst_fault_o), 64'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin : stim
    int cyc;
    int b_r, b_x, b_v, b_arv;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    chk_reset("reset");

    // zero-wait fetch, lower word
    m_ar_delay = 0; m_r_delay = 0; m_rresp = 2'b00;
    m_rdata = 64'h1111_2222_0000_0297;
    inst_ready_i = 1'b1;
    push_exp(32'h0000_0297, 64'h8000_0000, 1'b0);
    issue(64'h8000_0000);
    wait_valid(cyc);
    chk("lat_zero_wait", 64'(cyc), 64'd3);
    wait_idle(cyc);
    chk("pc_to_pc_gap", 64'(cyc), 64'd1);

    // upper word of the same beat
    push_exp(32'h1111_2222, 64'h8000_0004, 1'b0);
    issue(64'h8000_0004);
    chk("araddr_upper", mem_araddr_o, 64'h8000_0000);
    wait_valid(cyc);
    chk("lat_upper", 64'(cyc), 64'd3);
    wait_idle(cyc);

    // stalls on AR, R and IDU
    m_ar_delay = 3; m_r_delay = 5;
    m_rdata = 64'hdead_beef_cafe_f00d;
    inst_ready_i = 1'b0;
    push_exp(32'hcafe_f00d, 64'h8000_0010, 1'b0);
    b_x = n_xfer;
    issue(64'h8000_0010);
    wait_valid(cyc);
    chk("lat_stall", 64'(cyc), 64'd11);
    repeat (4) begin
      chk("stall_pc_ready", 64'(pc_ready_o), 64'd0);
      chk("stall_valid", 64'(inst_valid_o), 64'd1);
      @(negedge clk);
    end
    inst_ready_i = 1'b1;
    @(negedge clk);
    chk("stall_pc_ready_after", 64'(pc_ready_o), 64'd1);
    chk("stall_one_xfer", 64'(n_xfer - b_x), 64'd1);

    // flush while the request waits for arready
    m_ar_delay = 2; m_r_delay = 1;
    b_v = n_valid; b_r = n_r;
    issue(64'h8000_0020);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("arvalid_after_flush", 64'(mem_arvalid_o), 64'd1);
    wait_idle(cyc);
    chk("flush_req_r_absorbed", 64'(n_r - b_r), 64'd1);
    chk("flush_req_no_valid", 64'(n_valid - b_v), 64'd0);

    // misaligned pc faults without a bus access
    m_ar_delay = 0; m_r_delay = 0;
    b_arv = n_arv;
    push_exp(32'h0000_0013, 64'h8000_0002, 1'b1);
    issue(64'h8000_0002);
    wait_valid(cyc);
    chk("lat_misaligned", 64'(cyc), 64'd1);
    wait_idle(cyc);
    chk("misaligned_no_ar", 64'(n_arv - b_arv), 64'd0);

    // bus error response
    m_rresp = 2'b10;
    m_rdata = 64'h1234_5678_9abc_def0;
    push_exp(32'h0000_0013, 64'h8000_0008, 1'b1);
    issue(64'h8000_0008);
    wait_valid(cyc);
    chk("lat_rresp", 64'(cyc), 64'd3);
    wait_idle(cyc);
    m_rresp = 2'b00;

    // flush wins over ready while holding
    inst_ready_i = 1'b0;
    issue(64'h8000_0030);
    wait_valid(cyc);
    b_x = n_xfer;
    flush_i = 1'b1;
    inst_ready_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("flush_hold_pc_ready", 64'(pc_ready_o), 64'd1);
    chk("flush_hold_no_xfer", 64'(n_xfer - b_x), 64'd0);

`ifdef YSYX_22041461_IFU_TIMEOUT_EN
    // watchdog fires, late response drained before the next pc
    m_r_delay = 20;
    b_r = n_r;
    push_exp(32'h0000_0013, 64'h8000_0040, 1'b1);
    issue(64'h8000_0040);
    wait_valid(cyc);
    chk("lat_timeout", 64'(cyc), 64'd10);
    @(negedge clk);
    chk("late_pc_ready", 64'(pc_ready_o), 64'd0);
    chk("late_rready", 64'(mem_rready_o), 64'd1);
    wait_idle(cyc);
    chk("late_r_absorbed", 64'(n_r - b_r), 64'd1);
`endif

    // reset in the middle of WAIT
    m_r_delay = 10;
    issue(64'h8000_0050);
    @(negedge clk);
    chk("mid_wait_rready", 64'(mem_rready_o), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk_reset("mid_wait_reset");

    // recovery fetch after reset
    m_r_delay = 0;
    m_rdata = 64'h1111_2222_0000_0297;
    push_exp(32'h0000_0297, 64'h8000_0000, 1'b0);
    issue(64'h8000_0000);
    wait_valid(cyc);
    chk("lat_recovery", 64'(cyc), 64'd3);
    wait_idle(cyc);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22041461_ifu.md
Name: ysyx_22041461_ifu

Overview:
- Instruction fetch unit. Consumes the architectural pc from the PC register and issues one read per pc on an AXI4-Lite-style read channel to instruction memory.
- Returns the selected 32-bit instruction to decode (IDU) over a valid/ready handshake.
- Back-pressures the PC through pc_ready_o; pc may advance only on pc_valid_i && pc_ready_o.
- Handles redirect/flush with in-flight requests outstanding. One outstanding request maximum.

Parameters:
- TIMEOUT_CYCLES, 256: watchdog limit in cycles from AR handshake to R handshake. Used only with the optional feature.
- NOP_INST, 32'h0000_0013: instruction value driven on inst_o when the fetch faults.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- pc_i  in  64  fetch address from PC register
- pc_valid_i  in  1  pc_i holds a new address to fetch
- pc_ready_o  out  1  IFU can accept pc_i this cycle
- flush_i  in  1  redirect: discard all in-flight and held fetches
- mem_arvalid_o  out  1  read request valid
- mem_arready_i  in  1  memory accepts request
- mem_araddr_o  out  64  request address, 8-byte aligned (pc & ~7)
- mem_rvalid_i  in  1  read data valid
- mem_rready_o  out  1  IFU accepts read data
- mem_rdata_i  in  64  read data
- mem_rresp_i  in  2  response code; 0 = OKAY
- inst_valid_o  out  1  instruction valid to IDU
- inst_ready_i  in  1  IDU accepts instruction
- inst_o  out  32  instruction
- inst_pc_o  out  64  pc of inst_o
- inst_fault_o  out  1  fetch fault: misaligned pc, bus error, or timeout

Behaviour:
- Reset (rst==0 at posedge): state=IDLE; all outputs 0 except pc_ready_o=1.
  - Latched addr and pc are cleared to 0.
  - Reset overrides any transaction in flight. The external memory is reset by the same rst.
- States: IDLE, REQ, WAIT, HOLD, DROP.
- IDLE:
  - pc_ready_o=1.
  - On pc_valid_i && !flush_i, latch pc_i.
    - If pc_i[1:0]!=0: go to HOLD with fault=1 and inst=NOP_INST. No bus access is made.
    - Otherwise: go to REQ.
  - When flush_i=1, pc_valid_i is ignored and the state stays IDLE.
- REQ:
  - mem_arvalid_o=1, mem_araddr_o = {pc[63:3],3'b0}. Address is held stable until mem_arready_i.
  - On handshake: go to WAIT, or to DROP if a flush was recorded.
  - flush_i in REQ sets a drop_pending flag. arvalid is not withdrawn, per protocol.
- WAIT:
  - mem_rready_o=1.
  - On mem_rvalid_i: capture inst = pc[2] ? rdata[63:32] : rdata[31:0]; fault = (rresp!=0).
    - On a fault, inst=NOP_INST.
    - Go to HOLD.
  - flush_i in WAIT goes to DROP.
  - If flush_i and mem_rvalid_i occur in the same cycle, the data is consumed and discarded, and the state goes to IDLE.
- HOLD:
  - inst_valid_o=1. inst_o, inst_pc_o and inst_fault_o are stable while valid && !ready.
  - inst_ready_i goes to IDLE.
  - flush_i goes to IDLE with no transfer (flush wins over ready in the same cycle).
- DROP:
  - mem_rready_o=1. On mem_rvalid_i, discard the data and go to IDLE.
  - flush_i here has no additional effect.
- Latency: with zero-wait memory (arready and rvalid both asserted immediately), pc accepted at cycle 0, REQ at 1, WAIT at 2, inst_valid_o at 3.
  - Minimum pc-to-pc throughput is 4 cycles.
  - No overlap of fetches.
- pc_ready_o=0 in every state other than IDLE.

Optional Feature:
- Macro YSYX_22041461_IFU_TIMEOUT_EN.
- When defined: an 8..32-bit counter (width = clog2(TIMEOUT_CYCLES)+1) starts at 0 on the AR handshake and increments each cycle in WAIT.
  - If it reaches TIMEOUT_CYCLES-1 without rvalid: go to HOLD with fault=1, inst=NOP_INST, and set late_pending.
  - When IDLE is entered with late_pending=1, the IFU goes to DROP instead and waits for the late response before accepting a pc.
  - The counter resets to 0 on reset and on entering WAIT.
- When undefined: no counter and no late_pending; WAIT waits indefinitely.

Decomposition:
- Package ysyx_22041461_ifu_pkg holds:
  - state enum (IDLE, REQ, WAIT, HOLD, DROP)
  - RESP_OKAY=2'b00
  - NOP_INST default
  - function sel_word(rdata, a2)
- No sub-module required. The watchdog counter stays inline under the macro.

Test Plan:
- Zero-wait fetch: pc=0x8000_0000, rdata=0x1111_2222_0000_0297 → inst_o=0x0000_0297, inst_pc_o=0x8000_0000, fault=0, inst_valid_o in cycle 3.
- Upper word: pc=0x8000_0004, same rdata → mem_araddr_o=0x8000_0000, inst_o=0x1111_2222.
- Stalls: arready delayed 3 cycles, then rvalid delayed 5 cycles, then inst_ready_i low 4 cycles → araddr and inst_o held stable throughout; exactly one transfer occurs; pc_ready_o=0 until the IDU handshake.
- Flush in REQ: flush_i pulsed during arvalid with arready low 2 cycles → arvalid stays high until accepted; the later response is discarded (inst_valid_o never asserts); pc_ready_o returns to 1 after rvalid.
- Fault paths:
  - pc=0x8000_0002 → no arvalid; inst_fault_o=1, inst_o=0x0000_0013.
  - rresp=2'b10 → inst_fault_o=1.
- Timeout (macro on, TIMEOUT_CYCLES=8): rvalid withheld for 20 cycles → fault delivered after 8 WAIT cycles; the next pc is not accepted until the late rvalid is absorbed in DROP.
- Reset mid-WAIT: rst=0 for 1 cycle → state IDLE, all outputs per reset values, pc_ready_o=1.
